// File: rtl/cmd_proto_pkg.sv
// Shared constants and state encoding for the single-byte UART command protocol.
// Used by the host-side initiator and the remote command decoder.
package cmd_proto_pkg;

  localparam logic [7:0] CMD_LED_ON      = 8'hA1;
  localparam logic [7:0] CMD_LED_OFF     = 8'hA2;
  localparam logic [7:0] CMD_READ_STATUS = 8'hB1;
  localparam logic [7:0] CMD_RESET       = 8'hC1;

  localparam logic [7:0] RESP_ACK   = 8'h55;
  localparam logic [7:0] RESP_NACK  = 8'hEE;
  localparam logic [7:0] RESP_RESET = 8'hAA;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_MISMATCH = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_TX,
    S_WAIT_RESP,
    S_DONE
  } state_t;

  // Single fixed reply for every command except READ_STATUS, which accepts 0x00/0x01.
  function automatic logic [7:0] expected_reply(input logic [7:0] cmd);
    case (cmd)
      CMD_LED_ON: return RESP_ACK;
      CMD_RESET:  return RESP_RESET;
      default:    return RESP_NACK;
    endcase
  endfunction

endpackage

// File: rtl/resp_checker.sv
// Combinational reply classifier: (command, received byte) -> status and LED update.
module resp_checker
  import cmd_proto_pkg::*;
(
  input  logic [7:0] cmd,
  input  logic [7:0] rx,
  output logic [1:0] status,
  output logic       led_update_en,
  output logic       led_value
);

  always_comb begin
    status        = ST_MISMATCH;
    led_update_en = 1'b0;
    led_value     = 1'b0;
    if (cmd == CMD_READ_STATUS) begin
      if (rx[7:1] == 7'd0) begin
        status        = ST_OK;
        led_update_en = 1'b1;
        led_value     = rx[0];
      end
    end else if (rx == expected_reply(cmd)) begin
      status = ST_OK;
      // A confirmed RESET clears the LED; led_value stays 0.
      if (cmd == CMD_RESET) led_update_en = 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_initiator.sv
// Host-side UART command initiator: send one byte, await and classify one reply.
// Optional timeout retry is enabled by defining CMD_RETRY_EN.
module uart_cmd_initiator
  import cmd_proto_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [7:0] req_cmd,
  output logic       req_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic [1:0] resp_status,
  output logic [2:0] resp_attempts,
  output logic       led_state_seen
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, state_nx;
  logic [7:0]    cmd_q;
  logic [TW-1:0] timer;
  logic [2:0]    attempts;
  logic          timeout, retry;
  logic [1:0]    chk_status;
  logic          chk_led_en, chk_led_val;

  resp_checker u_chk (
    .cmd          (cmd_q),
    .rx           (rx_data),
    .status       (chk_status),
    .led_update_en(chk_led_en),
    .led_value    (chk_led_val)
  );

  // Timer reads 0 on the first WAIT_RESP cycle; expiry is taken when it has counted
  // TIMEOUT_CYCLES full cycles, so the result lands TIMEOUT_CYCLES+1 cycles after entry.
  assign timeout    = (timer == TW'(TIMEOUT_CYCLES));
  assign req_ready  = (state == S_IDLE) && !rst;
  assign tx_start   = (state == S_SEND);
  assign tx_data    = cmd_q;
  assign resp_valid = (state == S_DONE);

`ifdef CMD_RETRY_EN
  logic [2:0] attempts_q;
  assign attempts = attempts_q;
  assign retry    = timeout && (attempts_q <= 3'(MAX_RETRY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                attempts_q <= 3'd0;
    else if (state == S_IDLE && req_valid)                  attempts_q <= 3'd1;
    else if (state == S_WAIT_RESP && !rx_valid && retry)    attempts_q <= attempts_q + 3'd1;
  end
`else
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY != 0);
  assign attempts = 3'd1;
  assign retry    = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (req_valid) state_nx = S_SEND;
      S_SEND:      state_nx = S_WAIT_TX;
      S_WAIT_TX:   if (tx_done) state_nx = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (rx_valid)     state_nx = S_DONE;
        else if (timeout) state_nx = retry ? S_SEND : S_DONE;
      end
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q          <= 8'h00;
      timer          <= '0;
      resp_data      <= 8'h00;
      resp_status    <= ST_OK;
      resp_attempts  <= 3'd0;
      led_state_seen <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) cmd_q <= req_cmd;
      if (state == S_WAIT_TX)           timer <= '0;
      else if (state == S_WAIT_RESP)    timer <= timer + TW'(1);
      if (state == S_WAIT_RESP) begin
        // A byte arriving in the expiry cycle still wins over the timeout.
        if (rx_valid) begin
          resp_data     <= rx_data;
          resp_status   <= chk_status;
          resp_attempts <= attempts;
          if (chk_led_en) led_state_seen <= chk_led_val;
        end else if (timeout && !retry) begin
          resp_data     <= 8'h00;
          resp_status   <= ST_TIMEOUT;
          resp_attempts <= attempts;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Directed + randomized bench for uart_cmd_initiator against a transaction-level model.
`timescale 1ns/1ps
module tb_uart_cmd_initiator;

  localparam int T  = 16;
  localparam int MR = 2;
`ifdef CMD_RETRY_EN
  localparam int ATT_MAX = MR + 1;
`else
  localparam int ATT_MAX = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_cmd = 8'h00;
  logic       req_ready, tx_start, tx_done = 1'b0, rx_valid = 1'b0;
  logic [7:0] tx_data, rx_data = 8'h00, resp_data;
  logic       resp_valid, led_state_seen;
  logic [1:0] resp_status;
  logic [2:0] resp_attempts;

  int ncmp = 0;
  int nfail = 0;
  bit led_m = 1'b0;

  uart_cmd_initiator #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .rx_valid(rx_valid),
    .rx_data(rx_data), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_status(resp_status), .resp_attempts(resp_attempts), .led_state_seen(led_state_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reply classification straight from the protocol table: 0 OK, 1 MISMATCH.
  function automatic logic [1:0] model_status(input logic [7:0] c, input logic [7:0] r);
    case (c)
      8'hA1:   return (r == 8'h55) ? 2'd0 : 2'd1;
      8'hB1:   return (r == 8'h00 || r == 8'h01) ? 2'd0 : 2'd1;
      8'hC1:   return (r == 8'hAA) ? 2'd0 : 2'd1;
      default: return (r == 8'hEE) ? 2'd0 : 2'd1;
    endcase
  endfunction

  function automatic logic [7:0] good_reply(input logic [7:0] c);
    case (c)
      8'hA1:   return 8'h55;
      8'hB1:   return 8'($urandom_range(1));
      8'hC1:   return 8'hAA;
      default: return 8'hEE;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "/req_ready"}, 32'(req_ready), 0);
    check({tag, "/tx_start"},  32'(tx_start), 0);
    check({tag, "/tx_data"},   32'(tx_data), 0);
    check({tag, "/resp_valid"}, 32'(resp_valid), 0);
    check({tag, "/resp_data"}, 32'(resp_data), 0);
    check({tag, "/resp_status"}, 32'(resp_status), 0);
    check({tag, "/resp_attempts"}, 32'(resp_attempts), 0);
    check({tag, "/led"}, 32'(led_state_seen), 0);
  endtask

  // One full transaction. reply_att = attempt number that gets rx_b (0 = never reply).
  task automatic do_txn(input string tag, input logic [7:0] cmd, input int tx_lat, input int rx_lat,
                        input int reply_att, input logic [7:0] rx_b, input bit noise);
    int cyc = 0, ntx = 0, txc = -1, w = -1, seen_w = -1, exp_att, exp_lat;
    bit got = 1'b0;
    logic [1:0] exp_st;
    logic [7:0] exp_d;
    if (reply_att == 0) begin
      exp_st = 2'd2; exp_d = 8'h00; exp_att = ATT_MAX; exp_lat = T + 1;
    end else begin
      exp_st = model_status(cmd, rx_b); exp_d = rx_b; exp_att = reply_att; exp_lat = rx_lat + 1;
    end
    @(negedge clk);
    check({tag, "/ready"}, 32'(req_ready), 1);
    req_valid = 1'b1; req_cmd = cmd;
    while (!got && cyc < 400) begin
      @(negedge clk); cyc++;
      req_valid = 1'b0; tx_done = 1'b0; rx_valid = 1'b0;
      if (resp_valid) begin
        got = 1'b1; seen_w = w;
      end else if (tx_start) begin
        ntx++;
        if (ntx == 1) check({tag, "/start_lat"}, 32'(cyc), 1);
        else          check({tag, "/retry_gap"}, 32'(w), 32'(T + 1));
        check({tag, "/tx_data"}, 32'(tx_data), 32'(cmd));
        txc = tx_lat; w = -1;
        if (noise) begin rx_valid = 1'b1; rx_data = 8'($urandom); end
      end else if (txc > 0) begin
        txc--;
        if (txc == 0) begin
          tx_done = 1'b1; w = 0;
          check({tag, "/tx_hold"}, 32'(tx_data), 32'(cmd));
        end else if (noise && $urandom_range(1) == 1) begin
          rx_valid = 1'b1; rx_data = 8'($urandom);
        end
      end else if (w >= 0) begin
        if (ntx == reply_att && w == rx_lat) begin
          rx_valid = 1'b1; rx_data = rx_b;
        end else if (noise && $urandom_range(3) == 0) begin
          tx_done = 1'b1;
        end
        w++;
      end
    end
    check({tag, "/got_resp"}, 32'(got), 1);
    if (exp_st == 2'd0 && cmd == 8'hB1) led_m = rx_b[0];
    if (exp_st == 2'd0 && cmd == 8'hC1) led_m = 1'b0;
    if (got) begin
      check({tag, "/resp_data"}, 32'(resp_data), 32'(exp_d));
      check({tag, "/resp_status"}, 32'(resp_status), 32'(exp_st));
      check({tag, "/resp_attempts"}, 32'(resp_attempts), 32'(exp_att));
      check({tag, "/resp_lat"}, 32'(seen_w), 32'(exp_lat));
      check({tag, "/tx_pulses"}, 32'(ntx), 32'(exp_att));
      check({tag, "/led"}, 32'(led_state_seen), 32'(led_m));
      // A second byte in the DONE cycle must not produce another result.
      if (noise) begin rx_valid = 1'b1; rx_data = 8'($urandom); end
      @(negedge clk);
      rx_valid = 1'b0;
      check({tag, "/one_pulse"}, 32'(resp_valid), 0);
      check({tag, "/idle_ready"}, 32'(req_ready), 1);
    end
    tx_done = 1'b0; rx_valid = 1'b0;
  endtask

  initial begin
    int stray;
    logic [7:0] pick [5];
    pick[0] = 8'hA1; pick[1] = 8'hA2; pick[2] = 8'hB1; pick[3] = 8'hC1; pick[4] = 8'h00;

    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("post_reset/req_ready", 32'(req_ready), 1);

    stray = 0;
    repeat (3) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = 8'h55; tx_done = 1'b1;
      if (resp_valid || tx_start) stray++;
    end
    @(negedge clk); rx_valid = 1'b0; tx_done = 1'b0;
    if (resp_valid || tx_start) stray++;
    check("idle_stray", 32'(stray), 0);

    do_txn("a1_ok",      8'hA1, 10, 5, 1, 8'h55, 1'b0);
    do_txn("b1_led1",    8'hB1, 3, 2, 1, 8'h01, 1'b0);
    do_txn("c1_clear",   8'hC1, 4, 0, 1, 8'hAA, 1'b0);
    do_txn("b1_led1b",   8'hB1, 1, 7, 1, 8'h01, 1'b0);
    do_txn("a1_mm",      8'hA1, 2, 3, 1, 8'hEE, 1'b0);
    do_txn("b1_mm",      8'hB1, 2, 1, 1, 8'h02, 1'b0);
    do_txn("timeout",    8'hA2, 5, 0, 0, 8'h00, 1'b0);
`ifdef CMD_RETRY_EN
    do_txn("retry_ok",   8'hA1, 3, 4, 2, 8'h55, 1'b0);
    do_txn("retry_last", 8'hC1, 2, T, MR + 1, 8'hAA, 1'b0);
`endif
    do_txn("expiry_rx",  8'hA2, 2, T, 1, 8'hEE, 1'b0);
    do_txn("other_cmd",  8'h3C, 6, 1, 1, 8'hEE, 1'b1);
    do_txn("noise",      8'hB1, 8, 9, 1, 8'h00, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] c, r;
      int att;
      c = pick[$urandom_range(4)];
      if (c == 8'h00) c = 8'($urandom);
      r = ($urandom_range(2) != 0) ? good_reply(c) : 8'($urandom);
      att = ($urandom_range(5) == 0) ? 0 : int'($urandom_range(ATT_MAX - 1)) + 1;
      do_txn($sformatf("rand%0d", i), c, int'($urandom_range(12)) + 1, int'($urandom_range(T)),
             att, r, 1'($urandom_range(1)));
    end

    // Make led_state_seen nonzero so the reset clearing it is observable.
    do_txn("pre_rst", 8'hB1, 2, 2, 1, 8'h01, 1'b0);
    @(negedge clk); req_valid = 1'b1; req_cmd = 8'hA1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    stray = 0;
    repeat (3) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = 8'h55;
      if (resp_valid) stray++;
    end
    rst = 1'b0; rx_valid = 1'b0; led_m = 1'b0;
    #1 if (resp_valid) stray++;
    check("mid_rst/no_resp", 32'(stray), 0);
    check("mid_rst/ready", 32'(req_ready), 1);
    do_txn("after_rst", 8'hA1, 3, 2, 1, 8'h55, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
